// File: rtl/serial_credit_accumulator.sv
// Coin-credit front end: adds each accepted coin into the credit register one bit per cycle, LSB first.
// Latency: WIDTH add cycles + 1 check cycle (+1 vend cycle); coin_ready is low whenever the FSM is not IDLE.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_credit_accumulator #(
  parameter int WIDTH = 8,
  parameter int PRICE = 75
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  output logic             coin_ready,
  input  logic [WIDTH-1:0] coin_value,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] credit,
  output logic             vend,
  output logic             refund,
  output logic [WIDTH-1:0] refund_amount,
  output logic             overflow
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] PRICE_W  = WIDTH'(PRICE);

  typedef enum logic [1:0] {IDLE, ADD, CHECK, VEND} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  credit_q, credit_d;
  logic [WIDTH-1:0]  coin_q, coin_d;
  logic              carry_q, carry_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic              vend_q, vend_d;
  logic              refund_q, refund_d;
  logic [WIDTH-1:0]  refund_amount_q, refund_amount_d;
  logic              overflow_q, overflow_d;

  // Full-adder slice: credit bit + coin bit, then + carry.
  logic s0, c0, sum_bit, c1, carry_out;

  half_adder u_ha0 (.a_i(credit_q[bit_idx_q]), .b_i(coin_q[0]), .s_o(s0),      .c_o(c0));
  half_adder u_ha1 (.a_i(s0),                  .b_i(carry_q),   .s_o(sum_bit), .c_o(c1));
  assign carry_out = c0 | c1;

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    coin_d          = coin_q;
    carry_d         = carry_q;
    bit_idx_d       = bit_idx_q;
    vend_d          = 1'b0;
    refund_d        = 1'b0;
    refund_amount_d = '0;
    overflow_d      = overflow_q;
    case (state_q)
      IDLE: begin
        if (cancel) begin
          refund_d        = 1'b1;
          refund_amount_d = credit_q;
          credit_d        = '0;
        end else if (coin_valid) begin
          coin_d    = coin_value;
          carry_d   = 1'b0;
          bit_idx_d = '0;
          state_d   = ADD;
        end
      end
      ADD: begin
        credit_d[bit_idx_q] = sum_bit;
        coin_d              = coin_q >> 1;
        carry_d             = carry_out;
        if (bit_idx_q == LAST_IDX) begin
          bit_idx_d = '0;
          state_d   = CHECK;
          if (carry_out) begin
            credit_d   = '1;
            overflow_d = 1'b1;
          end
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      CHECK: begin
        if (credit_q >= PRICE_W) begin
          state_d = VEND;
          vend_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      VEND: begin
        credit_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      coin_q          <= '0;
      carry_q         <= 1'b0;
      bit_idx_q       <= '0;
      vend_q          <= 1'b0;
      refund_q        <= 1'b0;
      refund_amount_q <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      coin_q          <= coin_d;
      carry_q         <= carry_d;
      bit_idx_q       <= bit_idx_d;
      vend_q          <= vend_d;
      refund_q        <= refund_d;
      refund_amount_q <= refund_amount_d;
      overflow_q      <= overflow_d;
    end
  end

  // rst_n gating keeps coin_ready low throughout reset even though state reads IDLE.
  assign coin_ready    = rst_n && (state_q == IDLE) && !cancel;
  assign busy          = rst_n && (state_q != IDLE);
  assign credit        = credit_q;
  assign vend          = vend_q;
  assign refund        = refund_q;
  assign refund_amount = refund_amount_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_serial_credit_accumulator.sv
// Directed bench for serial_credit_accumulator (WIDTH=8, PRICE=75) with hand-computed expectations.
module tb_serial_credit_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic       coin_ready;
  logic [7:0] coin_value = 8'd0;
  logic       cancel = 1'b0;
  logic       busy;
  logic [7:0] credit;
  logic       vend;
  logic       refund;
  logic [7:0] refund_amount;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  serial_credit_accumulator #(.WIDTH(8), .PRICE(75)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_ready(coin_ready),
    .coin_value(coin_value), .cancel(cancel), .busy(busy), .credit(credit),
    .vend(vend), .refund(refund), .refund_amount(refund_amount), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Handshake one coin at edge T, then watch cycles T+1..T+12 on falling edges.
  // exp_vend_at = 0 means no vend expected; hold keeps coin_valid high while busy
  // and pulses cancel in the middle of ADD.
  task automatic run_coin(input string tag, input logic [7:0] v, input logic hold,
                          input int exp_vend_at, input int exp_ready_at,
                          input logic [7:0] exp_credit, input logic exp_ovf);
    int busy_cnt, vend_cnt, vend_at, ready_at, refund_cnt;
    logic [7:0] credit_at_vend;
    busy_cnt = 0; vend_cnt = 0; vend_at = 0; ready_at = 0; refund_cnt = 0;
    credit_at_vend = 8'd0;
    @(negedge clk);
    check({tag, "_rdy_pre"}, {31'd0, coin_ready}, 32'd1);
    coin_valid = 1'b1;
    coin_value = v;
    @(posedge clk);
    #1;
    if (!hold) coin_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (hold && k == 4) cancel = 1'b1;
      if (hold && k == 5) cancel = 1'b0;
      if (busy) busy_cnt++;
      if (refund) refund_cnt++;
      if (vend) begin
        vend_cnt++;
        vend_at = k;
        credit_at_vend = credit;
      end
      if (coin_ready && ready_at == 0) begin
        ready_at = k;
        coin_valid = 1'b0;
      end
    end
    check({tag, "_busy_cycles"}, busy_cnt, exp_ready_at - 1);
    check({tag, "_ready_at"}, ready_at, exp_ready_at);
    check({tag, "_vend_cnt"}, vend_cnt, (exp_vend_at != 0) ? 1 : 0);
    if (exp_vend_at != 0) begin
      check({tag, "_vend_at"}, vend_at, exp_vend_at);
      if (exp_ovf) check({tag, "_sat_credit"}, {24'd0, credit_at_vend}, 32'd255);
    end
    check({tag, "_refund_cnt"}, refund_cnt, 0);
    check({tag, "_credit"}, {24'd0, credit}, {24'd0, exp_credit});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic do_cancel(input string tag, input logic [7:0] exp_amt);
    @(negedge clk);
    cancel = 1'b1;
    coin_valid = 1'b1;
    coin_value = 8'd9;
    #1;
    check({tag, "_rdy_low"}, {31'd0, coin_ready}, 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    coin_valid = 1'b0;
    @(negedge clk);
    check({tag, "_refund"}, {31'd0, refund}, 32'd1);
    check({tag, "_amount"}, {24'd0, refund_amount}, {24'd0, exp_amt});
    check({tag, "_credit"}, {24'd0, credit}, 32'd0);
    check({tag, "_novend"}, {31'd0, vend}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_refund_end"}, {31'd0, refund}, 32'd0);
    check({tag, "_amount_end"}, {24'd0, refund_amount}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_ready", {31'd0, coin_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_credit", {24'd0, credit}, 32'd0);
    check("rst_outs", {29'd0, vend, refund, overflow}, 32'd0);
    check("rst_amount", {24'd0, refund_amount}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, coin_ready}, 32'd1);

    run_coin("c25a", 8'd25, 1'b0, 0, 10, 8'd25, 1'b0);
    run_coin("c25b", 8'd25, 1'b0, 0, 10, 8'd50, 1'b0);
    run_coin("c25c", 8'd25, 1'b0, 10, 11, 8'd0, 1'b0);

    run_coin("c50", 8'd50, 1'b0, 0, 10, 8'd50, 1'b0);
    run_coin("c250", 8'd250, 1'b0, 10, 11, 8'd0, 1'b1);

    run_coin("c40", 8'd40, 1'b0, 0, 10, 8'd40, 1'b1);
    do_cancel("cancel40", 8'd40);
    do_cancel("cancel0", 8'd0);

    run_coin("hold10", 8'd10, 1'b1, 0, 10, 8'd10, 1'b1);

    // Reset while ADD is working on bit 3.
    @(negedge clk);
    coin_valid = 1'b1;
    coin_value = 8'd30;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_credit", {24'd0, credit}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ready", {31'd0, coin_ready}, 32'd0);
    check("mrst_outs", {29'd0, vend, refund, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ready_after", {31'd0, coin_ready}, 32'd1);
    check("mrst_idle_after", {31'd0, busy}, 32'd0);

    run_coin("c75", 8'd75, 1'b0, 10, 11, 8'd0, 1'b0);
    run_coin("c74", 8'd74, 1'b0, 0, 10, 8'd74, 1'b0);
    run_coin("c0", 8'd0, 1'b0, 0, 10, 8'd74, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end
endmodule
